// File: rtl/ahb_slave_arbiter_burst.sv
// Per-slave AHB arbiter: priority plus round-robin winner selection.
// Holds the grant across fixed bursts, wait states, BUSY beats and bounded INCR bursts.
module ahb_slave_arbiter_burst #(
  parameter int N_MASTER = 3,
  parameter int PRIO_W   = 2,
  parameter int MAX_INCR = 16,
  localparam int MW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
  localparam int IW = $clog2(MAX_INCR) + 1
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic [N_MASTER-1:0]        hreq,
  input  logic [N_MASTER*PRIO_W-1:0] hprior,
  input  logic [1:0]                 htrans,
  input  logic [2:0]                 hburst,
  input  logic                       hwait,
  output logic [N_MASTER-1:0]        hgrant,
  output logic                       hsel,
  output logic [MW-1:0]              hmaster
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_t;

  state_t state_q, state_d;

  logic [N_MASTER-1:0] hgrant_d;
  logic                hsel_d;
  logic [MW-1:0]       hmaster_d;
  logic [3:0]          beat_q, beat_d;
  logic [IW-1:0]       incr_q, incr_d;
  logic [MW-1:0]       rr_q, rr_d;

  logic [MW-1:0]       win_idx;
  logic                win_vld;
  logic                is_incr;
  logic                is_fixed;
  logic [3:0]          fixed_len_m1;
  logic                owner_req;
  logic                rel;

  // Winner: highest priority, ties go to the first requester after rr_q.
  always_comb begin
    logic [PRIO_W-1:0] best;
    int j;
    win_idx = '0;
    win_vld = 1'b0;
    best    = '0;
    j       = 0;
    for (int k = 1; k <= N_MASTER; k++) begin
      j = (int'(rr_q) + k) % N_MASTER;
      if (hreq[j] &&
          (!win_vld || hprior[j*PRIO_W +: PRIO_W] > best)) begin
        win_vld = 1'b1;
        win_idx = MW'(j);
        best    = hprior[j*PRIO_W +: PRIO_W];
      end
    end
  end

  // Burst decode of the muxed payload.
  always_comb begin
    is_incr  = (hburst == 3'b001);
    is_fixed = (hburst[2:1] != 2'b00);
    unique case (hburst[2:1])
      2'b01:   fixed_len_m1 = 4'd3;
      2'b10:   fixed_len_m1 = 4'd7;
      2'b11:   fixed_len_m1 = 4'd15;
      default: fixed_len_m1 = 4'd0;
    endcase
    owner_req = hreq[hmaster];
  end

  // Next-state, counter update and grant decision.
  always_comb begin
    state_d   = state_q;
    hgrant_d  = hgrant;
    hmaster_d = hmaster;
    beat_d    = beat_q;
    incr_d    = incr_q;
    rr_d      = rr_q;
    rel       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d           = S_OWNED;
          hgrant_d          = '0;
          hgrant_d[win_idx] = 1'b1;
          hmaster_d         = win_idx;
          rr_d              = win_idx;
        end
      end
      S_OWNED: begin
        if (!hwait) begin
          unique case (htrans)
            T_NONSEQ: begin
              if (is_fixed) beat_d = fixed_len_m1;
              else if (!is_incr) beat_d = 4'd0;
              else incr_d = IW'(1);
            end
            T_SEQ: begin
              if (beat_q != 4'd0) beat_d = beat_q - 4'd1;
              if (is_incr && incr_q != IW'(MAX_INCR))
                incr_d = incr_q + IW'(1);
            end
            default: ;
          endcase
          rel = (htrans != T_BUSY) && (beat_d == 4'd0) &&
                ((htrans[1] && !is_incr) ||
                 (htrans == T_IDLE) ||
                 !owner_req ||
                 (is_incr && incr_d == IW'(MAX_INCR)));
        end
        if (rel) begin
          incr_d = '0;
          if (win_vld) begin
            hgrant_d          = '0;
            hgrant_d[win_idx] = 1'b1;
            hmaster_d         = win_idx;
            rr_d              = win_idx;
          end else begin
            state_d   = S_IDLE;
            hgrant_d  = '0;
            hmaster_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    hsel_d = |hgrant_d;
  end

  // State and registered outputs.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      hgrant  <= '0;
      hsel    <= 1'b0;
      hmaster <= '0;
      beat_q  <= '0;
      incr_q  <= '0;
      rr_q    <= MW'(N_MASTER - 1);
    end else begin
      state_q <= state_d;
      hgrant  <= hgrant_d;
      hsel    <= hsel_d;
      hmaster <= hmaster_d;
      beat_q  <= beat_d;
      incr_q  <= incr_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter_burst.sv
// Directed bench for ahb_slave_arbiter_burst.
// Expected grants are queued at drive time and checked after the edge.
module tb_ahb_slave_arbiter_burst;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_WRAP4  = 3'b010;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [2:0] hreq;
  logic [5:0] hprior;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hwait;
  logic [2:0] hgrant;
  logic       hsel;
  logic [1:0] hmaster;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] g;
    logic       mchk;
  } exp_t;

  exp_t sb[$];

  ahb_slave_arbiter_burst dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .hreq    (hreq),
    .hprior  (hprior),
    .htrans  (htrans),
    .hburst  (hburst),
    .hwait   (hwait),
    .hgrant  (hgrant),
    .hsel    (hsel),
    .hmaster (hmaster)
  );

  always #5 hclk = ~hclk;

  function automatic logic [1:0] idx_of(input logic [2:0] g);
    logic [1:0] r;
    r = 2'd0;
    if (g[1]) r = 2'd1;
    if (g[2]) r = 2'd2;
    return r;
  endfunction

  task automatic drv(input logic [2:0] rq, input logic [1:0] tr,
                     input logic [2:0] bu, input logic w);
    hreq   = rq;
    htrans = tr;
    hburst = bu;
    hwait  = w;
  endtask

  task automatic step(input logic [2:0] g, input logic mchk,
                      input string tag);
    exp_t e;
    e.g    = g;
    e.mchk = mchk;
    sb.push_back(e);
    @(posedge hclk);
    #1;
    e = sb.pop_front();
    total++;
    assert (hgrant === e.g) else begin
      bad++;
      $error("FAIL %s hgrant got=%b exp=%b", tag, hgrant, e.g);
    end
    total++;
    assert (hsel === (|e.g)) else begin
      bad++;
      $error("FAIL %s hsel got=%b exp=%b", tag, hsel, |e.g);
    end
    total++;
    assert ($onehot0(hgrant)) else begin
      bad++;
      $error("FAIL %s onehot hgrant got=%b exp=onehot0", tag, hgrant);
    end
    if (e.mchk) begin
      total++;
      assert (hmaster === idx_of(e.g)) else begin
        bad++;
        $error("FAIL %s hmaster got=%0d exp=%0d", tag, hmaster,
               idx_of(e.g));
      end
    end
  endtask

  initial begin
    hreset = 1'b1;
    hprior = '0;
    drv(3'b000, T_IDLE, B_SINGLE, 1'b0);
    step(3'b000, 1'b1, "reset");
    hreset = 1'b0;

    drv(3'b001, T_IDLE, B_SINGLE, 1'b0);
    step(3'b001, 1'b1, "t1_grant");
    drv(3'b000, T_IDLE, B_SINGLE, 1'b0);
    step(3'b000, 1'b0, "t1_idle");

    hreset = 1'b1;
    step(3'b000, 1'b1, "t2_reset");
    hreset = 1'b0;
    hprior = {2'd1, 2'd3, 2'd3};
    drv(3'b111, T_IDLE, B_SINGLE, 1'b0);
    step(3'b001, 1'b1, "t2_m0");
    drv(3'b111, T_NONSEQ, B_SINGLE, 1'b0);
    step(3'b010, 1'b1, "t2_m1");
    step(3'b001, 1'b1, "t2_m0b");
    step(3'b010, 1'b1, "t2_m1b");
    drv(3'b000, T_IDLE, B_SINGLE, 1'b0);
    step(3'b000, 1'b0, "t2_idle");

    hprior = {2'd0, 2'd3, 2'd1};
    drv(3'b001, T_IDLE, B_SINGLE, 1'b0);
    step(3'b001, 1'b1, "t3_grant");
    drv(3'b001, T_NONSEQ, B_INCR8, 1'b0);
    step(3'b001, 1'b1, "t3_b1");
    drv(3'b011, T_SEQ, B_INCR8, 1'b0);
    step(3'b001, 1'b1, "t3_b2");
    drv(3'b011, T_SEQ, B_INCR8, 1'b1);
    step(3'b001, 1'b1, "t3_wait1");
    step(3'b001, 1'b1, "t3_wait2");
    drv(3'b011, T_SEQ, B_INCR8, 1'b0);
    for (int i = 0; i < 5; i++) step(3'b001, 1'b1, "t3_hold");
    step(3'b010, 1'b1, "t3_switch");
    drv(3'b000, T_IDLE, B_SINGLE, 1'b0);
    step(3'b000, 1'b0, "t3_idle");

    hprior = '0;
    drv(3'b011, T_IDLE, B_SINGLE, 1'b0);
    step(3'b001, 1'b1, "t4_grant");
    drv(3'b011, T_NONSEQ, B_INCR, 1'b0);
    step(3'b001, 1'b1, "t4_b1");
    drv(3'b011, T_SEQ, B_INCR, 1'b0);
    for (int i = 0; i < 14; i++) step(3'b001, 1'b1, "t4_hold");
    step(3'b010, 1'b1, "t4_forced");
    drv(3'b000, T_IDLE, B_SINGLE, 1'b0);
    step(3'b000, 1'b0, "t4_idle");

    drv(3'b011, T_IDLE, B_SINGLE, 1'b0);
    step(3'b001, 1'b1, "t5_grant");
    drv(3'b011, T_NONSEQ, B_INCR4, 1'b0);
    step(3'b001, 1'b1, "t5_b1");
    drv(3'b011, T_SEQ, B_INCR4, 1'b0);
    step(3'b001, 1'b1, "t5_b2");
    drv(3'b011, T_BUSY, B_INCR4, 1'b0);
    step(3'b001, 1'b1, "t5_busy1");
    drv(3'b011, T_SEQ, B_INCR4, 1'b0);
    step(3'b001, 1'b1, "t5_b3");
    drv(3'b011, T_BUSY, B_INCR4, 1'b0);
    step(3'b001, 1'b1, "t5_busy2");
    step(3'b001, 1'b1, "t5_busy3");
    drv(3'b011, T_SEQ, B_INCR4, 1'b0);
    step(3'b010, 1'b1, "t5_switch");
    drv(3'b000, T_IDLE, B_SINGLE, 1'b0);
    step(3'b000, 1'b0, "t5_idle");

    drv(3'b001, T_IDLE, B_SINGLE, 1'b0);
    step(3'b001, 1'b1, "t6_grant");
    drv(3'b001, T_NONSEQ, B_WRAP4, 1'b0);
    step(3'b001, 1'b1, "t6_b1");
    hreset = 1'b1;
    drv(3'b001, T_SEQ, B_WRAP4, 1'b0);
    step(3'b000, 1'b1, "t6_reset");
    hreset = 1'b0;
    drv(3'b100, T_IDLE, B_SINGLE, 1'b0);
    step(3'b100, 1'b1, "t6_m2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
